perceptron_mac_ctrl: RTL and testbench

Sequencer for the shared pipelined signed multiplier (mult_gen_0, 32x32->64, fixed latency, no valid output) inside one perceptron. It accepts a stream of input/weight pairs and issues them to the multiplier. It tracks the in-flight products with a tag pipeline, accumulates them, adds a bias and presents the dot-product result on a valid/ready output. It sits between the layer scheduler (start/len/bias) and the activation stage.

---
 rtl/perceptron_pkg.sv | 25 ++
 rtl/mac_tag_pipe.sv | 32 +++
 rtl/perceptron_mac_ctrl.sv | 163 ++++++++++++++++
 tb/tb_perceptron_mac_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/perceptron_pkg.sv
// Shared definitions for the perceptron MAC sequencer.
//   - default widths and multiplier latency
//   - controller state encoding
//   - signed-add overflow helper
package perceptron_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int ACC_W_DEF    = 80;
    localparam int CNT_W_DEF    = 10;
    localparam int MULT_LAT_DEF = 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        DRAIN = 3'd2,
        BIAS  = 3'd3,
        DONE  = 3'd4
    } mac_state_t;

    // Two's-complement add overflowed: operands share a sign the sum lacks.
    function automatic logic add_ovf(input logic sign_a, input logic sign_b, input logic sign_s);
        return (sign_a == sign_b) && (sign_s != sign_a);
    endfunction

endpackage

// File: rtl/mac_tag_pipe.sv
// Valid-tag shift register that shadows the multiplier pipeline.
// Ports:
//   CLK, RST_N       clock, async active-low clear
//   push             a beat entered the multiplier this cycle
//   tag_last         product at the multiplier output belongs to a real beat
//   empty_but_last   no tags in flight other than (possibly) the last stage
module mac_tag_pipe #(
    parameter int MULT_LAT = 1
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic push,
    output logic tag_last,
    output logic empty_but_last
);

    localparam logic [MULT_LAT-1:0] LAST_MASK = MULT_LAT'(1) << (MULT_LAT - 1);

    logic [MULT_LAT-1:0] tags;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tags <= '0;
        end else begin
            tags <= (tags << 1) | MULT_LAT'(push);
        end
    end

    assign tag_last       = tags[MULT_LAT-1];
    assign empty_but_last = ((tags & ~LAST_MASK) == '0);

endmodule

// File: rtl/perceptron_mac_ctrl.sv
// Dot-product sequencer around a shared fixed-latency signed multiplier.
// Issues input/weight pairs to the multiplier, accumulates the tagged
// products, adds the bias and hands the result downstream on valid/ready.
// Ports:
//   CLK, RST_N                  clock, async active-low reset
//   start, len, bias, busy      scheduler side
//   in_valid/in_ready/in_a/in_b operand stream
//   mult_a, mult_b, mult_p      multiplier interface
//   out_valid/out_ready         result handshake
//   out_acc, out_ovf            signed result, sticky overflow for it
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | accepting operand beats, counting down remaining pairs
// DRAIN | waiting for in-flight products to land in the accumulator
// BIAS  | adding bias, capturing result
// DONE  | result presented until out_ready
module perceptron_mac_ctrl
    import perceptron_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ACC_W    = ACC_W_DEF,
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                start,
    input  logic [CNT_W-1:0]    len,
    input  logic [DATA_W-1:0]   bias,
    output logic                busy,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_a,
    input  logic [DATA_W-1:0]   in_b,
    output logic [DATA_W-1:0]   mult_a,
    output logic [DATA_W-1:0]   mult_b,
    input  logic [2*DATA_W-1:0] mult_p,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ACC_W-1:0]    out_acc,
    output logic                out_ovf
);

    mac_state_t state, state_d;

    logic [CNT_W-1:0]         rem_q, rem_d;
    logic signed [DATA_W-1:0] bias_q, bias_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [ACC_W-1:0]  out_acc_q, out_acc_d;
    logic                     ovf_q, ovf_d;
    logic                     out_ovf_q, out_ovf_d;

    logic                     beat;
    logic                     tag_last;
    logic                     tags_idle;
    logic signed [ACC_W-1:0]  prod_ext, bias_ext, sum_p, sum_b;
    logic                     ovf_p, ovf_b;

    assign in_ready = (state == LOAD);
    assign beat     = in_valid && in_ready;
    assign mult_a   = beat ? in_a : '0;
    assign mult_b   = beat ? in_b : '0;

    mac_tag_pipe #(
        .MULT_LAT (MULT_LAT)
    ) u_tag_pipe (
        .CLK            (CLK),
        .RST_N          (RST_N),
        .push           (beat),
        .tag_last       (tag_last),
        .empty_but_last (tags_idle)
    );

    // Product add happens whenever a tagged product emerges; the bias add is
    // chained behind it so one adder path serves the BIAS state.
    assign prod_ext = ACC_W'($signed(mult_p));
    assign bias_ext = ACC_W'(bias_q);
    assign sum_p    = tag_last ? (acc_q + prod_ext) : acc_q;
    assign ovf_p    = tag_last && add_ovf(acc_q[ACC_W-1], prod_ext[ACC_W-1], sum_p[ACC_W-1]);
    assign sum_b    = sum_p + bias_ext;
    assign ovf_b    = add_ovf(sum_p[ACC_W-1], bias_ext[ACC_W-1], sum_b[ACC_W-1]);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            rem_q     <= '0;
            bias_q    <= '0;
            acc_q     <= '0;
            ovf_q     <= 1'b0;
            out_acc_q <= '0;
            out_ovf_q <= 1'b0;
        end else begin
            state     <= state_d;
            rem_q     <= rem_d;
            bias_q    <= bias_d;
            acc_q     <= acc_d;
            ovf_q     <= ovf_d;
            out_acc_q <= out_acc_d;
            out_ovf_q <= out_ovf_d;
        end
    end

    always_comb begin
        state_d   = state;
        rem_d     = rem_q;
        bias_d    = bias_q;
        acc_d     = sum_p;
        ovf_d     = ovf_q || ovf_p;
        out_acc_d = out_acc_q;
        out_ovf_d = out_ovf_q;
        busy      = 1'b1;
        out_valid = 1'b0;

        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    acc_d     = '0;
                    ovf_d     = 1'b0;
                    out_ovf_d = 1'b0;
                    rem_d     = len;
                    bias_d    = bias;
                    state_d   = (len == '0) ? BIAS : LOAD;
                end
            end
            LOAD: begin
                if (beat) begin
                    rem_d = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // A last-stage tag still set here is consumed on this edge.
                if (tags_idle) begin
                    state_d = BIAS;
                end
            end
            BIAS: begin
                acc_d     = sum_b;
                ovf_d     = ovf_q || ovf_p || ovf_b;
                out_acc_d = sum_b;
                out_ovf_d = ovf_q || ovf_p || ovf_b;
                state_d   = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign out_acc = out_acc_q;
    assign out_ovf = out_ovf_q;

endmodule

// File: tb/tb_perceptron_mac_ctrl.sv
// Directed bench: two controllers (80-bit and 64-bit accumulators) share one
// stimulus stream, each with its own one-cycle signed multiplier model.
module tb_perceptron_mac_ctrl;

    logic        CLK;
    logic        RST_N;
    logic        start;
    logic [9:0]  len;
    logic [31:0] bias;
    logic        in_valid;
    logic [31:0] in_a, in_b;
    logic        out_ready;

    logic        busy, in_ready, out_valid, out_ovf;
    logic [31:0] mult_a, mult_b;
    logic [63:0] mult_p;
    logic [79:0] out_acc;

    logic        busy64, in_ready64, out_valid64, out_ovf64;
    logic [31:0] mult_a64, mult_b64;
    logic [63:0] mult_p64;
    logic [63:0] out_acc64;

    int n_cmp = 0;
    int n_bad = 0;

    int ta[3] = '{7456, -1145, 1872};
    int tb[3] = '{1525, -9243, 6723};

    perceptron_mac_ctrl #(.DATA_W(32), .ACC_W(80), .MULT_LAT(1), .CNT_W(10)) u_dut (
        .CLK(CLK), .RST_N(RST_N), .start(start), .len(len), .bias(bias), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .mult_a(mult_a), .mult_b(mult_b), .mult_p(mult_p),
        .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc), .out_ovf(out_ovf)
    );

    perceptron_mac_ctrl #(.DATA_W(32), .ACC_W(64), .MULT_LAT(1), .CNT_W(10)) u_dut64 (
        .CLK(CLK), .RST_N(RST_N), .start(start), .len(len), .bias(bias), .busy(busy64),
        .in_valid(in_valid), .in_ready(in_ready64), .in_a(in_a), .in_b(in_b),
        .mult_a(mult_a64), .mult_b(mult_b64), .mult_p(mult_p64),
        .out_valid(out_valid64), .out_ready(out_ready), .out_acc(out_acc64), .out_ovf(out_ovf64)
    );

    // Multiplier models: registered signed product, latency 1, no reset.
    always @(posedge CLK) begin
        mult_p   <= $signed(mult_a) * $signed(mult_b);
        mult_p64 <= $signed(mult_a64) * $signed(mult_b64);
    end

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!out_valid && n < budget) begin
            tick();
            n++;
        end
        chk("out_valid_timeout", out_valid, 1'b1);
    endtask

    initial begin
        RST_N = 1'b0; start = 1'b0; len = '0; bias = '0;
        in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;

        #3;
        chk("rst_busy",      busy,      1'b0);
        chk("rst_in_ready",  in_ready,  1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_acc",   out_acc,   80'd0);
        chk("rst_out_ovf",   out_ovf,   1'b0);
        repeat (2) @(posedge CLK);
        #1 RST_N = 1'b1;
        tick();

        // 1: back-to-back beats, bias 0
        start = 1'b1; len = 10'd3; bias = 32'd0;
        tick();
        start = 1'b0;
        chk("t1_busy",     busy,     1'b1);
        chk("t1_in_ready", in_ready, 1'b1);
        in_valid = 1'b1; in_a = ta[0]; in_b = tb[0];
        #1;
        chk("t1_mult_a", mult_a, 32'd7456);
        tick();
        in_a = ta[1]; in_b = tb[1];
        tick();
        in_a = ta[2]; in_b = tb[2];
        tick();
        in_valid = 1'b0;
        #1;
        chk("t1_drain_ready", in_ready, 1'b0);
        chk("t1_mult_a_idle", mult_a,   32'd0);
        tick();
        chk("t1_valid_e4", out_valid, 1'b0);
        tick();
        chk("t1_valid_e5", out_valid, 1'b1);
        chk("t1_acc",      out_acc,   80'd34539091);
        chk("t1_ovf",      out_ovf,   1'b0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t1_idle", busy, 1'b0);

        // 2: two-cycle gaps between beats, bias -100
        start = 1'b1; len = 10'd3; bias = -32'sd100;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_a = ta[i]; in_b = tb[i];
            tick();
            in_valid = 1'b0;
            if (i < 2) begin
                repeat (2) begin
                    tick();
                    chk("t2_gap_ready", in_ready, 1'b1);
                end
            end
        end
        wait_valid(10);
        chk("t2_acc", out_acc, 80'd34538991);
        chk("t2_ovf", out_ovf, 1'b0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // 3: len 0 goes straight to bias
        start = 1'b1; len = 10'd0; bias = -32'sd5;
        tick();
        start = 1'b0;
        chk("t3_valid_e0", out_valid, 1'b0);
        chk("t3_busy",     busy,      1'b1);
        chk("t3_no_load",  in_ready,  1'b0);
        tick();
        chk("t3_valid_e1", out_valid, 1'b1);
        chk("t3_acc",      out_acc,   80'hFFFF_FFFF_FFFF_FFFF_FFFB);
        chk("t3_acc64",    out_acc64, 64'hFFFF_FFFF_FFFF_FFFB);

        // 4: hold in DONE while start is pulsed
        for (int i = 0; i < 4; i++) begin
            start = 1'b1; len = 10'd5;
            tick();
            chk("t4_acc_hold",   out_acc,   80'hFFFF_FFFF_FFFF_FFFF_FFFB);
            chk("t4_busy",       busy,      1'b1);
            chk("t4_valid_hold", out_valid, 1'b1);
        end
        out_ready = 1'b1;
        tick();
        chk("t4_to_idle", busy, 1'b0);
        start = 1'b0; out_ready = 1'b0;
        tick();
        chk("t4_start_ignored", busy, 1'b0);

        // 5: reset mid-run, then a clean single-beat run
        start = 1'b1; len = 10'd4; bias = 32'd0;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_a = 32'd11; in_b = 32'd13;
        tick();
        in_a = 32'd17; in_b = 32'd19;
        tick();
        RST_N = 1'b0;
        #1;
        chk("t5_busy",      busy,      1'b0);
        chk("t5_in_ready",  in_ready,  1'b0);
        chk("t5_out_valid", out_valid, 1'b0);
        chk("t5_out_acc",   out_acc,   80'd0);
        chk("t5_out_ovf",   out_ovf,   1'b0);
        chk("t5_mult_a",    mult_a,    32'd0);
        in_valid = 1'b0;
        RST_N = 1'b1;
        tick();
        start = 1'b1; len = 10'd1; bias = 32'd0;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_a = 32'd47425; in_b = 32'd963;
        tick();
        in_valid = 1'b0;
        wait_valid(10);
        chk("t5_acc", out_acc, 80'd45670275);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // 6: overflow in the 64-bit accumulator, none in the 80-bit one
        start = 1'b1; len = 10'd2; bias = 32'd0;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_a = 32'h8000_0000; in_b = 32'h8000_0000;
        tick();
        tick();
        in_valid = 1'b0;
        wait_valid(10);
        chk("t6_acc64", out_acc64, 64'h8000_0000_0000_0000);
        chk("t6_ovf64", out_ovf64, 1'b1);
        chk("t6_acc80", out_acc,   80'h0000_8000_0000_0000_0000);
        chk("t6_ovf80", out_ovf,   1'b0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        start = 1'b1; len = 10'd0; bias = 32'd0;
        tick();
        start = 1'b0;
        chk("t6_ovf_cleared", out_ovf64, 1'b0);
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
